// File: rtl/minmax_dist_engine.sv
// ============================================================================
// Module   : minmax_dist_engine
// Purpose  : Min/max absolute pairwise distance over N_VALS signed 16-bit words
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minmax_dist_engine #(
  parameter int N_VALS    = 32,
  parameter int BASE_ADDR = 0,
  parameter int RES_ADDR  = 66,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic [15:0]       min_dist,
  output logic [15:0]       max_dist,
  output logic [4:0]        min_j,
  output logic [4:0]        min_k,
  output logic [4:0]        max_j,
  output logic [4:0]        max_k
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LOAD  = 3'd1;
  localparam logic [2:0] c_ST_CMP   = 3'd2;
  localparam logic [2:0] c_ST_WRITE = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  localparam logic [5:0] c_LAST_BYTE = 6'(2 * N_VALS - 1);
  localparam logic [4:0] c_LAST_K    = 5'(N_VALS - 1);
  localparam logic [4:0] c_LAST_J    = 5'(N_VALS - 2);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [5:0]  r_cnt;
  logic [1:0]  r_wcnt;
  logic [4:0]  r_j;
  logic [4:0]  r_k;
  logic [15:0] r_vals [0:N_VALS-1];
  logic [15:0] r_min;
  logic [15:0] r_max;
  logic [4:0]  r_min_j;
  logic [4:0]  r_min_k;
  logic [4:0]  r_max_j;
  logic [4:0]  r_max_k;
  logic        r_done;

  logic [16:0] w_diff;
  logic [16:0] w_neg;
  logic [15:0] w_dist;
  logic        w_last_pair;

  // 17-bit difference cannot overflow; its magnitude always fits in 16 bits
  assign w_diff      = {r_vals[r_j][15], r_vals[r_j]} - {r_vals[r_k][15], r_vals[r_k]};
  assign w_neg       = -w_diff;
  assign w_dist      = w_diff[16] ? w_neg[15:0] : w_diff[15:0];
  assign w_last_pair = (r_j == c_LAST_J) && (r_k == c_LAST_K);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (!start) w_next = c_ST_LOAD;
      c_ST_LOAD:  if (start) w_next = c_ST_IDLE;
                  else if (r_cnt == c_LAST_BYTE) w_next = c_ST_CMP;
      c_ST_CMP:   if (start) w_next = c_ST_IDLE;
                  else if (w_last_pair) w_next = c_ST_WRITE;
      c_ST_WRITE: if (start) w_next = c_ST_IDLE;
                  else if (r_wcnt == 2'd3) w_next = c_ST_DONE;
      c_ST_DONE:  if (start) w_next = c_ST_IDLE;
      default:    w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (r_state)
      c_ST_LOAD: mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(r_cnt);
      c_ST_WRITE: begin
        mem_addr  = ADDR_W'(RES_ADDR) + ADDR_W'(r_wcnt);
        mem_wr_en = 1'b1;
        case (r_wcnt)
          2'd0:    mem_wr_data = r_min[15:8];
          2'd1:    mem_wr_data = r_min[7:0];
          2'd2:    mem_wr_data = r_max[15:8];
          default: mem_wr_data = r_max[7:0];
        endcase
      end
      default: ;
    endcase
  end

  // Operand storage is fully rewritten by every LOAD, so it needs no reset
  always_ff @(posedge clk) begin
    if (r_state == c_ST_LOAD) begin
      if (r_cnt[0]) r_vals[r_cnt[5:1]][7:0]  <= mem_rd_data;
      else          r_vals[r_cnt[5:1]][15:8] <= mem_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_min   <= 16'hFFFF;
      r_max   <= 16'h0000;
      r_min_j <= '0;
      r_min_k <= '0;
      r_max_j <= '0;
      r_max_k <= '0;
    end else begin
      r_done <= (w_next == c_ST_DONE);
      case (r_state)
        c_ST_IDLE: begin
          r_cnt <= '0;
          if (!start) begin
            r_min   <= 16'hFFFF;
            r_max   <= 16'h0000;
            r_min_j <= '0;
            r_min_k <= '0;
            r_max_j <= '0;
            r_max_k <= '0;
          end
        end
        c_ST_LOAD: begin
          r_cnt <= r_cnt + 6'd1;
          r_j   <= 5'd0;
          r_k   <= 5'd1;
        end
        c_ST_CMP: begin
          r_wcnt <= 2'd0;
          if (w_dist < r_min) begin
            r_min   <= w_dist;
            r_min_j <= r_j;
            r_min_k <= r_k;
          end
          if (w_dist > r_max) begin
            r_max   <= w_dist;
            r_max_j <= r_j;
            r_max_k <= r_k;
          end
          if (r_k == c_LAST_K) begin
            r_j <= r_j + 5'd1;
            r_k <= r_j + 5'd2;
          end else begin
            r_k <= r_k + 5'd1;
          end
        end
        c_ST_WRITE: r_wcnt <= r_wcnt + 2'd1;
        default: ;
      endcase
    end
  end

  assign done     = r_done;
  assign min_dist = r_min;
  assign max_dist = r_max;
  assign min_j    = r_min_j;
  assign min_k    = r_min_k;
  assign max_j    = r_max_j;
  assign max_k    = r_max_k;

endmodule

`default_nettype wire

// File: tb/tb_minmax_dist_engine.sv
// ============================================================================
// Module   : tb_minmax_dist_engine
// Purpose  : Directed self-checking bench for minmax_dist_engine
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minmax_dist_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic [15:0] min_dist;
  logic [15:0] max_dist;
  logic [4:0]  min_j;
  logic [4:0]  min_k;
  logic [4:0]  max_j;
  logic [4:0]  max_k;

  minmax_dist_engine #(
    .N_VALS(32), .BASE_ADDR(0), .RES_ADDR(66), .ADDR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .min_dist(min_dist), .max_dist(max_dist),
    .min_j(min_j), .min_k(min_k), .max_j(max_j), .max_k(max_k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem      [0:255];
  logic [7:0]  init_mem [0:255];
  logic        load_req;
  logic [15:0] vals     [0:31];

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
  end

  int checks;
  int failures;

  logic [15:0] exp_min, exp_max;
  logic [4:0]  exp_min_j, exp_min_k, exp_max_j, exp_max_k;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: exhaustive j<k sweep with strict compares
  task automatic compute_model();
    int mn, mx, d;
    mn = 65535; mx = 0;
    exp_min_j = 0; exp_min_k = 0; exp_max_j = 0; exp_max_k = 0;
    for (int j = 0; j < 32; j++) begin
      for (int k = j + 1; k < 32; k++) begin
        d = int'($signed(vals[j])) - int'($signed(vals[k]));
        if (d < 0) d = -d;
        if (d < mn) begin mn = d; exp_min_j = 5'(j); exp_min_k = 5'(k); end
        if (d > mx) begin mx = d; exp_max_j = 5'(j); exp_max_k = 5'(k); end
      end
    end
    exp_min = 16'(mn);
    exp_max = 16'(mx);
  endtask

  // Called at a negedge while the DUT is idle; presets result bytes
  task automatic load_data(input logic [31:0] preset);
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) begin
      init_mem[2*i]   = vals[i][15:8];
      init_mem[2*i+1] = vals[i][7:0];
    end
    init_mem[66] = preset[31:24];
    init_mem[67] = preset[23:16];
    init_mem[68] = preset[15:8];
    init_mem[69] = preset[7:0];
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    compute_model();
  endtask

  // Expected bus/done behaviour t edges after the run-starting edge
  task automatic timeline(input int t);
    logic [7:0] ea;
    logic       ew, ed;
    logic [7:0] eb;
    ea = 8'h00; ew = 1'b0; ed = 1'b0; eb = 8'h00;
    if (t < 64) ea = 8'(t);
    else if (t >= 560 && t < 564) begin
      ea = 8'(66 + t - 560);
      ew = 1'b1;
      case (t - 560)
        0:       eb = exp_min[15:8];
        1:       eb = exp_min[7:0];
        2:       eb = exp_max[15:8];
        default: eb = exp_max[7:0];
      endcase
    end else if (t >= 564) ed = 1'b1;
    chk("mem_addr", mem_addr, ea);
    chk("mem_wr_en", mem_wr_en, ew);
    chk("done", done, ed);
    if (ew) chk("mem_wr_data", mem_wr_data, eb);
  endtask

  task automatic run_loop(input int upto);
    for (int t = 0; t <= upto; t++) begin
      @(negedge clk);
      timeline(t);
    end
  endtask

  task automatic check_results();
    chk("min_dist", min_dist, exp_min);
    chk("max_dist", max_dist, exp_max);
    chk("min_j", min_j, exp_min_j);
    chk("min_k", min_k, exp_min_k);
    chk("max_j", max_j, exp_max_j);
    chk("max_k", max_k, exp_max_k);
    chk("mem66", mem[66], exp_min[15:8]);
    chk("mem67", mem[67], exp_min[7:0]);
    chk("mem68", mem[68], exp_max[15:8]);
    chk("mem69", mem[69], exp_max[7:0]);
  endtask

  task automatic check_reset_vals();
    chk("rst_done", done, 1'b0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_wr_en", mem_wr_en, 1'b0);
    chk("rst_wr_data", mem_wr_data, 8'h00);
    chk("rst_min", min_dist, 16'hFFFF);
    chk("rst_max", max_dist, 16'h0000);
    chk("rst_idx", {min_j, min_k, max_j, max_k}, 20'h0);
  endtask

  task automatic full_run();
    start = 1'b0;
    run_loop(564);
    check_results();
    start = 1'b1;
    @(negedge clk);
    chk("done_drop", done, 1'b0);
    chk("hold_min", min_dist, exp_min);
    chk("hold_max", max_dist, exp_max);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b1; load_req = 1'b0;
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // Identical values: every distance is zero
    for (int i = 0; i < 32; i++) vals[i] = 16'h1234;
    load_data(32'hA5A5A5A5);
    chk("pin1_min", exp_min, 16'h0000);
    chk("pin1_minpair", {exp_min_j, exp_min_k}, {5'd0, 5'd1});
    chk("pin1_max", exp_max, 16'h0000);
    chk("pin1_maxpair", {exp_max_j, exp_max_k}, {5'd0, 5'd0});
    full_run();

    // Full-range extremes
    for (int i = 0; i < 32; i++) vals[i] = 16'h0000;
    vals[0]  = 16'h8000;
    vals[31] = 16'h7FFF;
    load_data(32'hA5A5A5A5);
    chk("pin2_max", exp_max, 16'hFFFF);
    chk("pin2_maxpair", {exp_max_j, exp_max_k}, {5'd0, 5'd31});
    chk("pin2_min", exp_min, 16'h0000);
    chk("pin2_minpair", {exp_min_j, exp_min_k}, {5'd1, 5'd2});
    full_run();
    chk("pin2_mem68", mem[68], 8'hFF);
    chk("pin2_mem69", mem[69], 8'hFF);

    // Random operands
    for (int i = 0; i < 32; i++) vals[i] = 16'($urandom);
    load_data(32'h5A5A5A5A);
    full_run();

    // Abort mid-compare, then a complete run on the same data
    for (int i = 0; i < 32; i++) vals[i] = 16'($urandom_range(0, 2000)) - 16'd1000;
    load_data(32'hFFFF0000);
    start = 1'b0;
    run_loop(299);
    start = 1'b1;
    @(negedge clk);
    chk("abort_addr", mem_addr, 8'h00);
    chk("abort_wr_en", mem_wr_en, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_done", done, 1'b0);
      chk("abort_wr", mem_wr_en, 1'b0);
    end
    chk("abort_mem", {mem[66], mem[67], mem[68], mem[69]}, 32'hFFFF0000);
    full_run();

    // Reset mid-load with start held low
    for (int i = 0; i < 32; i++) vals[i] = 16'(i * 977) ^ 16'h3C5A;
    load_data(32'h11223344);
    start = 1'b0;
    run_loop(39);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    run_loop(564);
    check_results();
    start = 1'b1;
    @(negedge clk);
    chk("rst_run_done_drop", done, 1'b0);

    // Back-to-back run with fresh data
    for (int i = 0; i < 32; i++) vals[i] = 16'($urandom);
    vals[5] = vals[20];
    load_data(32'h00000000);
    full_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
